// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage valid/ready execute unit.
// Stage 1 registers the operands and the ALUControl code. Stage 2 registers the result and NZCV flags plus an illegal-code flag.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int M = WIDTH - 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             ill;
  } rsp_t;

  logic       r_s1_valid;
  req_t       r_s1;
  logic       r_s2_valid;
  rsp_t       r_s2;
  rsp_t       w_rsp;
  logic       w_s2_adv;
  logic       w_cap;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;
  logic       w_add_v;
  logic       w_sub_v;

  // Stage 2 moves when it is empty or its result is being consumed.
  // That makes out_ready -> in_ready a combinational path.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !rst && (!r_s1_valid || w_s2_adv);
  assign w_cap    = in_valid && in_ready;

  // Shared adder outputs. The subtract is a + ~b + 1, so the carry-out means "no borrow".
  assign w_sum   = {1'b0, r_s1.a} + {1'b0, r_s1.b};
  assign w_dif   = {1'b0, r_s1.a} + {1'b0, ~r_s1.b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_add_v = (r_s1.a[M] == r_s1.b[M]) && (w_sum[M] != r_s1.a[M]);
  assign w_sub_v = (r_s1.a[M] != r_s1.b[M]) && (w_dif[M] != r_s1.a[M]);

  // Compute the result and flags from the stage-1 contents.
  // An illegal code yields zero and sets the illegal flag.
  always_comb begin
    w_rsp = '0;
    case (r_s1.op)
      3'b000: begin
        w_rsp.res = w_sum[M:0];
        w_rsp.c   = w_sum[WIDTH];
        w_rsp.v   = w_add_v;
      end
      3'b001: begin
        w_rsp.res = w_dif[M:0];
        w_rsp.c   = w_dif[WIDTH];
        w_rsp.v   = w_sub_v;
      end
      3'b010:  w_rsp.res = r_s1.a & r_s1.b;
      3'b011:  w_rsp.res = r_s1.a | r_s1.b;
      3'b101:  w_rsp.res = {{(WIDTH-1){1'b0}}, w_dif[M] ^ w_sub_v};
      default: w_rsp.ill = 1'b1;
    endcase
    w_rsp.z = (w_rsp.res == '0);
    w_rsp.n = w_rsp.res[M];
  end

  // Stage 1 operand register.
  // It captures on handshake, drains when handed to stage 2, and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_cap) begin
      r_s1_valid <= 1'b1;
      r_s1       <= '{op: ALUControl, a: src_a, b: src_b};
    end else if (r_s1_valid && w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 result register.
  // The outputs stay frozen while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2 <= w_rsp;
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_s2.res;
  assign zero      = r_s2.z;
  assign negative  = r_s2.n;
  assign carry     = r_s2.c;
  assign overflow  = r_s2.v;
  assign illegal   = r_s2.ill;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit. Expected values are hand-computed.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, negative, carry, overflow, illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {zero, negative, carry, overflow, illegal}
  function automatic logic [4:0] flags();
    return {zero, negative, carry, overflow, illegal};
  endfunction

  // Issue one op with out_ready=1, then check latency, result and flags.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic [4:0] exp_flg);
    out_ready = 1'b1; in_valid = 1'b1; ALUControl = op; src_a = a; src_b = b;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(exp_res));
    chk({tag, ".flags"}, 64'(flags()), 64'(exp_flg));
  endtask

  // Return the bench to an empty pipeline.
  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUControl = 3'b000; src_a = '0; src_b = '0;

    // Reset state.
    tick(); tick();
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.flags", 64'(flags()), 64'd0);
    rst = 1'b0;
    #1;

    // 1: single add
    run_one("add5p3", 3'b000, 32'h5, 32'h3, 32'h8, 5'b00000);

    // 2: sign/carry edges
    run_one("sub3m5", 3'b001, 32'h3, 32'h5, 32'hFFFF_FFFE, 5'b01000);
    run_one("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b01010);
    run_one("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b10100);

    // 3: slt, logic, illegal
    run_one("slt_m1_1", 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00000);
    run_one("slt_min_max", 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 5'b00000);
    run_one("slt_false", 3'b101, 32'h5, 32'h3, 32'h0, 5'b10000);
    run_one("and", 3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 5'b00000);
    run_one("or", 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 5'b01000);
    run_one("ill111", 3'b111, 32'h1234, 32'h5678, 32'h0, 5'b10001);
    run_one("ill100", 3'b100, 32'h1, 32'h1, 32'h0, 5'b10001);
    drain();

    // 4: backpressure. Op k is add (k*0x10)+1, so its result is k*0x10+1.
    out_ready = 1'b0;
    in_valid = 1'b1; ALUControl = 3'b000; src_a = 32'h10; src_b = 32'h1;
    chk("bp.rdy1", 64'(in_ready), 64'd1);
    tick();
    src_a = 32'h20;
    chk("bp.rdy2", 64'(in_ready), 64'd1);
    tick();
    src_a = 32'h30;
    chk("bp.rdy_drop", 64'(in_ready), 64'd0);
    chk("bp.valid", 64'(out_valid), 64'd1);
    chk("bp.res_hold0", 64'(result), 64'h11);
    tick();
    chk("bp.rdy_stall1", 64'(in_ready), 64'd0);
    chk("bp.res_hold1", 64'(result), 64'h11);
    chk("bp.flg_hold1", 64'(flags()), 64'd0);
    tick();
    chk("bp.rdy_stall2", 64'(in_ready), 64'd0);
    chk("bp.res_hold2", 64'(result), 64'h11);
    chk("bp.valid_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_release", 64'(in_ready), 64'd1);
    tick();
    src_a = 32'h40;
    chk("bp.out2", 64'(result), 64'h21);
    chk("bp.rdy3", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.out3", 64'(result), 64'h31);
    chk("bp.out3_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp.out4", 64'(result), 64'h41);
    chk("bp.out4_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp.empty", 64'(out_valid), 64'd0);

    // 5: full throughput. Op c is add c + 0x100.
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; ALUControl = 3'b000; src_a = 32'(c); src_b = 32'h100;
        #1;
        chk($sformatf("tp.rdy%0d", c), 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 8) begin
        chk($sformatf("tp.valid%0d", c), 64'(out_valid), 64'd1);
        chk($sformatf("tp.res%0d", c), 64'(result), 64'(32'h100 + 32'(c - 1)));
      end else begin
        chk($sformatf("tp.idle%0d", c), 64'(out_valid), 64'd0);
      end
    end

    // 6: reset with two ops in flight
    in_valid = 1'b1; ALUControl = 3'b000; src_a = 32'h1; src_b = 32'h1;
    tick();
    src_a = 32'h2;
    tick();
    chk("mr.pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; src_a = 32'h3;
    #1;
    chk("mr.rdy_in_rst", 64'(in_ready), 64'd0);
    tick();
    chk("mr.valid", 64'(out_valid), 64'd0);
    chk("mr.result", 64'(result), 64'd0);
    chk("mr.flags", 64'(flags()), 64'd0);
    chk("mr.rdy_in_rst2", 64'(in_ready), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("mr.no_ghost1", 64'(out_valid), 64'd0);
    tick();
    chk("mr.no_ghost2", 64'(out_valid), 64'd0);
    run_one("mr.sub10m3", 3'b001, 32'd10, 32'd3, 32'd7, 5'b00100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
